// File: rtl/sw_pkg.sv
// Shared types and defaults for the switch debouncer.
// Optional feature macro: SW_AUTOREPEAT_EN (enables the oStep auto-repeat).
package sw_pkg;

  // Per-channel debounce FSM states; the "CHK" states are the
  // tentative phases where a level change is being confirmed.
  typedef enum logic [1:0] {
    S_LOW      = 2'd0,
    S_CHK_HIGH = 2'd1,
    S_HIGH     = 2'd2,
    S_CHK_LOW  = 2'd3
  } state_t;

  // 10 ms at 50 MHz.
  localparam int DB_CYCLES_DEFAULT     = 500000;
  // 0.5 s at 50 MHz.
  localparam int REPEAT_CYCLES_DEFAULT = 25000000;

  // The debounced level is high in both high-side states.
  function automatic logic isHighState(input state_t s);
    return (s == S_HIGH) || (s == S_CHK_LOW);
  endfunction

endpackage

// File: rtl/sw_debounce_bit.sv
// One debounce channel: 2-flop synchronizer, confirm FSM with stability
// counter, edge pulses and the step command.
// Optional feature macro: SW_AUTOREPEAT_EN -- when defined, oStep repeats
// every REPEAT_CYCLES while the channel is high; otherwise oStep = oRise.
// There are no handshakes here: oRise/oFall/oStep are single-cycle strobes
// with no back-pressure; a consumer must sample them on the cycle they occur.
module sw_debounce_bit
  import sw_pkg::*;
#(
  parameter int DB_CYCLES     = DB_CYCLES_DEFAULT,
  parameter int REPEAT_CYCLES = REPEAT_CYCLES_DEFAULT
) (
  input  logic       iClk,
  input  logic       iRst,
  input  logic       iSW,
  output logic       oSW,
  output logic       oRise,
  output logic       oFall,
  output logic       oStep,
  output logic [1:0] oState
);

  localparam int CNT_W = $clog2(DB_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  // Reject illegal configurations at elaboration time.
  if (DB_CYCLES < 2 || REPEAT_CYCLES < 2) begin : gBadParam
    $error("sw_debounce_bit: DB_CYCLES and REPEAT_CYCLES must be >= 2");
  end

  logic           syncMeta;
  logic           syncOut;
  state_t         state;
  logic [CNT_W-1:0] cnt;
  logic           swReg;
  logic           riseReg;
  logic           fallReg;
  logic           acceptRise;
  logic           acceptFall;

  // Two-flop synchronizer; only syncOut is used downstream.
  always_ff @(posedge iClk) begin
    if (iRst) begin
      syncMeta <= 1'b0;
      syncOut  <= 1'b0;
    end else begin
      syncMeta <= iSW;
      syncOut  <= syncMeta;
    end
  end

  // Edges on which a confirmed change is taken: the last cycle of a full run.
  always_comb begin
    acceptRise = (state == S_CHK_HIGH) && syncOut  && (cnt == CNT_LAST);
    acceptFall = (state == S_CHK_LOW)  && !syncOut && (cnt == CNT_LAST);
  end

  // Confirm FSM: a change must persist DB_CYCLES cycles; any return aborts.
  always_ff @(posedge iClk) begin
    if (iRst) begin
      state   <= S_LOW;
      cnt     <= '0;
      swReg   <= 1'b0;
      riseReg <= 1'b0;
      fallReg <= 1'b0;
    end else begin
      riseReg <= 1'b0;
      fallReg <= 1'b0;
      case (state)
        S_LOW: begin
          if (syncOut) begin
            state <= S_CHK_HIGH;
            cnt   <= CNT_ONE;
          end
        end
        S_CHK_HIGH: begin
          if (!syncOut) begin
            state <= S_LOW;
            cnt   <= '0;
          end else if (acceptRise) begin
            state   <= S_HIGH;
            cnt     <= '0;
            swReg   <= 1'b1;
            riseReg <= 1'b1;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        S_HIGH: begin
          if (!syncOut) begin
            state <= S_CHK_LOW;
            cnt   <= CNT_ONE;
          end
        end
        S_CHK_LOW: begin
          if (syncOut) begin
            state <= S_HIGH;
            cnt   <= '0;
          end else if (acceptFall) begin
            state   <= S_LOW;
            cnt     <= '0;
            swReg   <= 1'b0;
            fallReg <= 1'b1;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        default: begin
          state <= S_LOW;
          cnt   <= '0;
        end
      endcase
    end
  end

`ifdef SW_AUTOREPEAT_EN
  localparam int RPT_W = $clog2(REPEAT_CYCLES);
  localparam logic [RPT_W-1:0] RPT_LAST = RPT_W'(REPEAT_CYCLES - 1);

  logic [RPT_W-1:0] rptCnt;
  logic             stepReg;

  // Auto-repeat: step on acceptance, then every REPEAT_CYCLES while high.
  always_ff @(posedge iClk) begin
    if (iRst) begin
      rptCnt  <= '0;
      stepReg <= 1'b0;
    end else begin
      stepReg <= 1'b0;
      if (acceptRise) begin
        rptCnt  <= '0;
        stepReg <= 1'b1;
      end else if (isHighState(state) && !acceptFall) begin
        if (rptCnt == RPT_LAST) begin
          rptCnt  <= '0;
          stepReg <= 1'b1;
        end else begin
          rptCnt <= rptCnt + RPT_W'(1);
        end
      end else begin
        rptCnt <= '0;
      end
    end
  end

  assign oStep = stepReg;
`else
  // Without auto-repeat the step command is simply the rising-edge pulse.
  assign oStep = riseReg;
`endif

  assign oSW    = swReg;
  assign oRise  = riseReg;
  assign oFall  = fallReg;
  assign oState = state;

endmodule

// File: rtl/sw_debounce.sv
// Multi-channel switch debouncer top: WIDTH independent sw_debounce_bit
// channels whose outputs are concatenated. oState exposes each channel's
// FSM state (2 bits per channel, channel i at [2*i +: 2]) for debug.
// Optional feature macro: SW_AUTOREPEAT_EN (auto-repeating oStep).
module sw_debounce
  import sw_pkg::*;
#(
  parameter int WIDTH         = 2,
  parameter int DB_CYCLES     = DB_CYCLES_DEFAULT,
  parameter int REPEAT_CYCLES = REPEAT_CYCLES_DEFAULT
) (
  input  logic               iClk,
  input  logic               iRst,
  input  logic [WIDTH-1:0]   iSW,
  output logic [WIDTH-1:0]   oSW,
  output logic [WIDTH-1:0]   oRise,
  output logic [WIDTH-1:0]   oFall,
  output logic [WIDTH-1:0]   oStep,
  output logic [2*WIDTH-1:0] oState
);

  // One fully independent channel per switch bit.
  for (genvar i = 0; i < WIDTH; i++) begin : gChan
    sw_debounce_bit #(
      .DB_CYCLES     (DB_CYCLES),
      .REPEAT_CYCLES (REPEAT_CYCLES)
    ) uBit (
      .iClk   (iClk),
      .iRst   (iRst),
      .iSW    (iSW[i]),
      .oSW    (oSW[i]),
      .oRise  (oRise[i]),
      .oFall  (oFall[i]),
      .oStep  (oStep[i]),
      .oState (oState[2*i +: 2])
    );
  end

endmodule

// File: doc/sw_debounce.md
SW_DEBOUNCE -- requirements
Module: sw_debounce

Interface
REQ-001 Parameter WIDTH, default 2: number of independent switch channels.
REQ-002 Parameter DB_CYCLES, default 500000: consecutive stable cycles needed to accept a level change (10 ms at 50 MHz); legal range >= 2.
REQ-003 Parameter REPEAT_CYCLES, default 25000000: auto-repeat period in cycles (used only with SW_AUTOREPEAT_EN); legal range >= 2.
REQ-004 iClk  input  1  sole clock; all logic on its rising edge.
REQ-005 iRst  input  1  reset, synchronous, active-high.
REQ-006 iSW  input  WIDTH  raw switch levels, asynchronous to iClk, may bounce.
REQ-007 oSW  output  WIDTH  debounced level per channel, registered.
REQ-008 oRise  output  WIDTH  one-cycle pulse on each accepted 0->1 change of oSW.
REQ-009 oFall  output  WIDTH  one-cycle pulse on each accepted 1->0 change of oSW.
REQ-010 oStep  output  WIDTH  one-cycle step command per channel, for the LED rotator's direction inputs.

Function
REQ-011 Each iSW bit SHALL pass through a 2-flop synchronizer; only the second flop output (sync) feeds the logic.
REQ-012 Channels SHALL be fully independent; simultaneous events on several bits SHALL produce simultaneous pulses.
REQ-013 Per-channel FSM SHALL have states S_LOW, S_CHK_HIGH, S_HIGH and S_CHK_LOW.
- S_LOW, sync=1: go to S_CHK_HIGH, cnt=1.
- S_CHK_HIGH, sync=0: go to S_LOW, cnt=0.
- S_CHK_HIGH, sync=1, cnt=DB_CYCLES-1: go to S_HIGH.
- S_CHK_HIGH, otherwise: cnt+1.
- S_HIGH, S_CHK_LOW: mirror image of the above.
REQ-014 oSW SHALL be 1 exactly in S_HIGH and S_CHK_LOW, and be registered.
REQ-015 A sync value that differs from oSW for DB_CYCLES consecutive cycles SHALL update oSW on the edge that ends the DB_CYCLES-th cycle; total latency from a clean iSW edge to oSW is DB_CYCLES+2 cycles.
REQ-016 Any single-cycle return of sync to the oSW value during a check state SHALL abort the check and clear the counter, so oSW never toggles for bursts shorter than DB_CYCLES.
REQ-017 oRise or oFall SHALL be high only in the first cycle oSW shows the new value; they are never both high on one bit.
REQ-018 The counter SHALL be $clog2(DB_CYCLES) bits, saturate never, and be zero outside check states.
REQ-019 oStep SHALL equal oRise when SW_AUTOREPEAT_EN is undefined.

Reset
REQ-020 While iRst=1 the following SHALL be 0 on the next edge: sync flops, counters and all outputs; the FSM state SHALL be S_LOW.
REQ-021 Reset during a check state SHALL discard the partial count.
REQ-022 A switch held high across reset release SHALL produce one oRise after DB_CYCLES+2 cycles.

Configuration
REQ-023 With SW_AUTOREPEAT_EN defined, oStep SHALL pulse together with oRise, and then every REPEAT_CYCLES cycles while the channel stays in S_HIGH or S_CHK_LOW.
REQ-024 The repeat counter SHALL clear on the oRise cycle, on leaving high states and on reset.
REQ-025 Without SW_AUTOREPEAT_EN, no repeat counter SHALL exist in the netlist.

Structure
REQ-026 Package sw_pkg SHALL hold:
- the state typedef (2-bit enum of the four states);
- DB_CYCLES_DEFAULT and REPEAT_CYCLES_DEFAULT.
REQ-027 The per-channel synchronizer, FSM, counter and pulse logic SHALL live in sub-module sw_debounce_bit, instantiated WIDTH times by a generate loop.
REQ-028 The top level SHALL only concatenate the per-bit outputs.

Verification (sim with WIDTH=2, DB_CYCLES=4, REPEAT_CYCLES=8)
REQ-029 Hold iRst=1 with iSW=11, then release -> outputs 00 during reset; oSW=11 with oRise=11 for one cycle at 6 cycles after release.
REQ-030 iSW[0] high for 3 cycles, then low -> oSW, oRise, oFall and oStep stay 00.
REQ-031 iSW[1] bounce 1,0,1,1,0,1,1,1,1 held -> exactly one oRise[1] pulse, 6 cycles after the last 0->1; later clean release -> one oFall[1] pulse after 6 cycles.
REQ-032 Both bits rise on the same cycle -> oRise=11 on the same cycle, one pulse each.
REQ-033 iSW[0] held 30 cycles after acceptance -> with SW_AUTOREPEAT_EN, oStep[0] at acceptance and at +8, +16 and +24; without the macro, a single pulse.
REQ-034 iRst pulsed for 1 cycle during S_CHK_HIGH at cnt=3 -> no oRise; acceptance recounted from zero (6 cycles after reset release).
